alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
- REQ-001 SHALL provide parameter WIDTH, default 4, meaning operand/result width in bits (legal range 2..32).
- REQ-002 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
- REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
- REQ-004 SHALL provide port in_valid  input  1  operation request.
- REQ-005 SHALL provide port in_ready  output  1  block can accept a request this cycle.
- REQ-006 SHALL provide port A  input  WIDTH  operand A, unsigned / two's complement.
- REQ-007 SHALL provide port B  input  WIDTH  operand B.
- REQ-008 SHALL provide port sel  input  3  opcode.
- REQ-009 SHALL provide port out_valid  output  1  one-cycle pulse, C/flags hold a new result.
- REQ-010 SHALL provide port C  output  WIDTH  registered result.
- REQ-011 SHALL provide ports carry, zero, ovf  output  1 each  registered flags.

Function
- REQ-012 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; in_valid SHALL be ignored while in_ready=0.
- REQ-013 SHALL decode sel: 0 ADD A+B, 1 AND A&B, 2 SUB A-B, 3 OR A|B, 4 XOR A^B, 5 NOT ~A, 6 MUL A*B, 7 ACC acc+A.
- REQ-014 SHALL implement FSM states IDLE and MUL; in_ready=1 exactly in IDLE.
- REQ-015 Single-cycle ops (sel 0-5,7): C/flags SHALL update on the accepting edge, out_valid=1 for the following cycle, state stays IDLE; back-to-back accepts every cycle SHALL be supported.
- REQ-016 MUL: accepting edge SHALL latch A, B, clear 2*WIDTH-bit product, enter MUL; shift-add one bit of B per edge for WIDTH edges; on the WIDTH-th edge C/flags update, out_valid=1 next cycle, state returns to IDLE (in_ready=1 in that same cycle).
- REQ-017 MUL result: C = product[WIDTH-1:0]; carry=1 iff product[2*WIDTH-1:WIDTH] != 0; ovf=0.
- REQ-018 ADD/ACC: carry = unsigned carry-out; ovf = signed overflow (operands same sign, result sign differs).
- REQ-019 SUB: carry = borrow (1 iff A<B unsigned); ovf = signed overflow of A-B.
- REQ-020 AND/OR/XOR/NOT: carry=0, ovf=0.
- REQ-021 zero SHALL equal (C==0) for every result.
- REQ-022 ACC SHALL update an internal WIDTH-bit accumulator acc <= acc+A (wrap modulo 2^WIDTH) and drive C=new acc; B ignored; no other opcode alters acc.
- REQ-023 C and flags SHALL hold their last value between results; out_valid SHALL never be high two consecutive cycles for one request.

Reset
- REQ-024 rst_n=0 SHALL immediately force state=IDLE, C=0, carry=0, zero=0, ovf=0, out_valid=0, acc=0, MUL counter/product=0; in_ready=1 while held in reset and after release.
- REQ-025 Reset asserted during MUL SHALL abort the operation with no out_valid pulse; first accept after release SHALL behave as from power-up.

Verification (WIDTH=4)
- REQ-026 ADD A=8,B=6 -> next cycle out_valid=1, C=14, carry=0, ovf=0, zero=0.
- REQ-027 AND A=8,B=6 -> C=0, zero=1, carry=0; ADD A=9,B=9 -> C=2, carry=1, ovf=1.
- REQ-028 SUB A=3,B=5 -> C=14, carry=1, ovf=0; SUB A=8,B=1 -> C=7, ovf=1.
- REQ-029 MUL A=7,B=5 -> in_ready=0 for 4 cycles, requests ignored, then out_valid=1, C=3, carry=1, in_ready=1.
- REQ-030 ACC A=9 twice after reset -> C=9 then C=2, carry=1; interleaved ADD does not change acc.
- REQ-031 rst_n=0 two cycles into MUL -> outputs 0, no out_valid; subsequent ADD 1+1 -> C=2 one cycle later.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- small sequential ALU with a multi-cycle shift-add multiplier.
//
// Eight operations selected by sel:
//   0 ADD  A+B      1 AND  A&B      2 SUB  A-B      3 OR   A|B
//   4 XOR  A^B      5 NOT  ~A       6 MUL  A*B      7 ACC  acc+A
// Every operation except MUL completes on the accepting edge. MUL takes
// WIDTH further edges, and the block refuses new requests while it runs.
//
// Handshake: a request is taken on a rising edge where in_valid && in_ready.
// in_valid is ignored while in_ready is low. out_valid is a one-cycle pulse
// marking the cycle in which C and the flags first show a new result. C and
// the flags hold their value until the next result.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   high exactly while the FSM is IDLE
//   A, B       operands (unsigned / two's complement)
//   sel        opcode
//   out_valid  one-cycle result strobe
//   C          registered result
//   carry      carry-out (ADD/ACC), borrow (SUB), high-half-nonzero (MUL)
//   zero       C == 0
//   ovf        signed overflow (ADD/ACC/SUB), otherwise 0
//   dbg_state  current FSM state (0 = IDLE, 1 = MUL)
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] C,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             dbg_state
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ACC = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     acc;

  // Multiplier datapath: the multiplicand shifts left and the multiplier
  // shifts right, so bit 0 of mplier always selects the current partial.
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   product;
  logic [CNT_W-1:0]     mul_cnt;

  logic                 accept;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   prod_next;

  // Single-cycle result path
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [WIDTH:0]       acc_sum;
  logic [WIDTH-1:0]     op_c;
  logic                 op_carry;
  logic                 op_ovf;

  assign in_ready  = (state == S_IDLE);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign mul_last  = (mul_cnt == CNT_W'(WIDTH - 1));
  assign prod_next = product + (mplier[0] ? mcand : '0);

  assign add_sum  = {1'b0, A}   + {1'b0, B};
  assign sub_diff = {1'b0, A}   - {1'b0, B};
  assign acc_sum  = {1'b0, acc} + {1'b0, A};

  always_comb begin
    op_c     = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    case (sel)
      OP_ADD: begin
        op_c     = add_sum[WIDTH-1:0];
        op_carry = add_sum[WIDTH];
        // Overflow: operands share a sign, result sign differs.
        op_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: op_c = A & B;
      OP_SUB: begin
        op_c     = sub_diff[WIDTH-1:0];
        // The extra top bit of the zero-extended difference is the borrow.
        op_carry = sub_diff[WIDTH];
        // Overflow: operands differ in sign, result sign differs from A.
        op_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:  op_c = A | B;
      OP_XOR: op_c = A ^ B;
      OP_NOT: op_c = ~A;
      OP_ACC: begin
        op_c     = acc_sum[WIDTH-1:0];
        op_carry = acc_sum[WIDTH];
        op_ovf   = (acc[WIDTH-1] == A[WIDTH-1]) && (acc_sum[WIDTH-1] != acc[WIDTH-1]);
      end
      default: begin
        // MUL does not use this path.
        op_c     = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      mul_cnt   <= '0;
      out_valid <= 1'b0;
      C         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (sel == OP_MUL) begin
              mcand   <= {{WIDTH{1'b0}}, A};
              mplier  <= B;
              product <= '0;
              mul_cnt <= '0;
              state   <= S_MUL;
            end else begin
              C         <= op_c;
              carry     <= op_carry;
              ovf       <= op_ovf;
              zero      <= (op_c == '0);
              out_valid <= 1'b1;
              if (sel == OP_ACC) begin
                acc <= op_c;
              end
            end
          end
        end
        S_MUL: begin
          product <= prod_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_last) begin
            // The final partial is folded in here so the result appears
            // on the WIDTH-th edge rather than one edge later.
            C         <= prod_next[WIDTH-1:0];
            carry     <= |prod_next[2*WIDTH-1:WIDTH];
            ovf       <= 1'b0;
            zero      <= (prod_next[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 4).
//
// A reference model follows the request stream with plain integer
// arithmetic; a per-cycle compare on the falling edge checks every output
// against it. Directed operations with hand-worked literal answers pin the
// model, then randomized traffic (including stray resets) exercises it.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int WIDTH = 4;
  localparam longint M    = longint'(1) << WIDTH;
  localparam longint HALF = M / 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       sel;
  logic             out_valid;
  logic [WIDTH-1:0] C;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic             dbg_state;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .C         (C),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  int               busy_cnt = 0;
  longint           acc_m    = 0;
  logic             m_valid  = 1'b0;
  logic [WIDTH-1:0] m_c      = '0;
  logic             m_carry  = 1'b0;
  logic             m_zero   = 1'b0;
  logic             m_ovf    = 1'b0;
  longint           pend_c;
  bit               pend_carry;

  function automatic longint sx(input longint v);
    return (v >= HALF) ? v - M : v;
  endfunction

  function automatic bit out_of_range(input longint v);
    return (v < -HALF) || (v > HALF - 1);
  endfunction

  function automatic void model_op(input int s, input longint a, input longint b,
                                   input longint accv, output longint c,
                                   output bit cy, output bit ov);
    longint full;
    cy = 1'b0;
    ov = 1'b0;
    case (s)
      0: begin full = a + b; c = full % M; cy = (full >= M); ov = out_of_range(sx(a) + sx(b)); end
      1: c = a & b;
      2: begin full = a - b; c = (full + M) % M; cy = (a < b); ov = out_of_range(sx(a) - sx(b)); end
      3: c = a | b;
      4: c = a ^ b;
      5: c = (M - 1) - a;
      6: begin full = a * b; c = full % M; cy = (full >= M); end
      default: begin full = accv + a; c = full % M; cy = (full >= M); ov = out_of_range(sx(accv) + sx(a)); end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    longint c;
    bit cy;
    bit ov;
    if (!rst_n) begin
      busy_cnt = 0;
      acc_m    = 0;
      m_valid  = 1'b0;
      m_c      = '0;
      m_carry  = 1'b0;
      m_zero   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          m_c     = WIDTH'(pend_c);
          m_carry = pend_carry;
          m_ovf   = 1'b0;
          m_zero  = (pend_c == 0);
          m_valid = 1'b1;
        end
      end else if (in_valid) begin
        model_op(int'(sel), longint'(A), longint'(B), acc_m, c, cy, ov);
        if (sel == 3'd6) begin
          pend_c     = c;
          pend_carry = cy;
          busy_cnt   = WIDTH;
        end else begin
          m_c     = WIDTH'(c);
          m_carry = cy;
          m_ovf   = ov;
          m_zero  = (c == 0);
          m_valid = 1'b1;
          if (sel == 3'd7) acc_m = c;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [WIDTH+4:0] exp_v;
    logic [WIDTH+4:0] got_v;
    exp_v = {(busy_cnt == 0), m_valid, m_c, m_carry, m_zero, m_ovf};
    got_v = {in_ready, out_valid, C, carry, zero, ovf};
    n_checks++;
    if (got_v === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL cycle_cmp t=%0t got ready=%b valid=%b C=%0d cy=%b z=%b ov=%b want ready=%b valid=%b C=%0d cy=%b z=%b ov=%b",
               $time, in_ready, out_valid, C, carry, zero, ovf,
               exp_v[WIDTH+4], exp_v[WIDTH+3], exp_v[WIDTH+2:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic check_lit(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issue one single-cycle op from idle; check {out_valid,C,carry,zero,ovf}
  // one cycle after the accepting edge.
  task automatic single_op(input string name, input logic [2:0] s, input int a, input int b,
                           input int ec, input bit ecy, input bit ez, input bit eov);
    logic [WIDTH+3:0] want;
    in_valid = 1'b1;
    sel      = s;
    A        = WIDTH'(a);
    B        = WIDTH'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    want = {1'b1, WIDTH'(ec), ecy, ez, eov};
    check_lit(name, longint'({out_valid, C, carry, zero, ovf}), longint'(want));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = '0;
    A        = '0;
    B        = '0;
    @(posedge clk); #1;
    check_lit("reset_outputs", longint'({in_ready, out_valid, C, carry, zero, ovf}), longint'(9'b1_0_0000_000));
    apply_reset();

    // Directed operations with worked answers.
    single_op("add_8_6",  3'd0, 8, 6, 14, 1'b0, 1'b0, 1'b0);
    single_op("and_8_6",  3'd1, 8, 6,  0, 1'b0, 1'b1, 1'b0);
    single_op("add_9_9",  3'd0, 9, 9,  2, 1'b1, 1'b0, 1'b1);
    single_op("sub_3_5",  3'd2, 3, 5, 14, 1'b1, 1'b0, 1'b0);
    single_op("sub_8_1",  3'd2, 8, 1,  7, 1'b0, 1'b0, 1'b1);
    single_op("not_5",    3'd5, 5, 0, 10, 1'b0, 1'b0, 1'b0);
    single_op("xor_12_10",3'd4, 12, 10, 6, 1'b0, 1'b0, 1'b0);

    // MUL 7*5 = 35: busy for 4 cycles while a competing request is ignored.
    in_valid = 1'b1; sel = 3'd6; A = 4'd7; B = 4'd5;
    @(posedge clk); #1;
    sel = 3'd0; A = 4'd1; B = 4'd1;
    for (int i = 0; i < 4; i++) begin
      check_lit($sformatf("mul_busy_%0d", i), longint'({in_ready, out_valid}), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_lit("mul_7_5", longint'({in_ready, out_valid, C, carry, zero, ovf}), longint'(9'b1_1_0011_100));

    // Accumulator: ACC 9, ADD (must not touch acc), ACC 9 -> wraps to 2.
    apply_reset();
    single_op("acc_9_first",  3'd7, 9, 3, 9, 1'b0, 1'b0, 1'b0);
    single_op("add_1_1_mid",  3'd0, 1, 1, 2, 1'b0, 1'b0, 1'b0);
    single_op("acc_9_second", 3'd7, 9, 0, 2, 1'b1, 1'b0, 1'b1);

    // Reset two cycles into a MUL aborts it with no strobe.
    single_op("add_1_2", 3'd0, 1, 2, 3, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; sel = 3'd6; A = 4'd15; B = 4'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_lit("mul_abort_reset", longint'({in_ready, out_valid, C, carry, zero, ovf}), longint'(9'b1_0_0000_000));
    repeat (2) begin @(posedge clk); #1; end
    check_lit("mul_abort_no_valid", longint'(out_valid), 0);
    rst_n = 1'b1;
    single_op("add_after_abort", 3'd0, 1, 1, 2, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      sel      = 3'($urandom_range(0, 7));
      A        = WIDTH'($urandom);
      B        = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
